// File: rtl/qspi_flash_arbiter_if.sv
// Requester and reader signal bundle for qspi_flash_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the flash reader.
interface qspi_flash_arbiter_if #(
    parameter int LEN_W = 8
);
    logic             req0;
    logic [23:0]      addr0;
    logic [LEN_W-1:0] len0;
    logic             gnt0;
    logic             rvalid0;
    logic             rready0;
    logic             done0;

    logic             req1;
    logic [23:0]      addr1;
    logic [LEN_W-1:0] len1;
    logic             gnt1;
    logic             rvalid1;
    logic             rready1;
    logic             done1;

    logic [7:0]       rdata;

    logic             rd_read;
    logic [23:0]      rd_addr;
    logic             rd_ready;
    logic [7:0]       rd_data;

    modport slave (
        input  req0, addr0, len0, rready0,
        input  req1, addr1, len1, rready1,
        input  rd_ready, rd_data,
        output gnt0, rvalid0, done0,
        output gnt1, rvalid1, done1,
        output rdata, rd_read, rd_addr
    );

    modport master (
        output req0, addr0, len0, rready0,
        output req1, addr1, len1, rready1,
        output rd_ready, rd_data,
        input  gnt0, rvalid0, done0,
        input  gnt1, rvalid1, done1,
        input  rdata, rd_read, rd_addr
    );
endinterface

// File: rtl/qspi_flash_arbiter.sv
// Round-robin burst arbiter sharing one qspi_flash_reader between two requesters.
// Define QSPI_ARB_TIMEOUT_EN to reissue a read when the reader stays silent for TIMEOUT WAIT cycles.
module qspi_flash_arbiter #(
    parameter int LEN_W        = 8,
    parameter int FLUSH_CYCLES = 32,
    parameter int TIMEOUT      = 63
) (
    input  logic                  clk,
    input  logic                  rst,
    qspi_flash_arbiter_if.slave   bus
);
    typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

    localparam int             FL_W       = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(FLUSH_CYCLES - 1);

    state_t           state, state_d;
    logic [FL_W-1:0]  flush_cnt, flush_cnt_d;
    logic             last_owner, last_owner_d;
    logic             owner, owner_d;
    logic [23:0]      cur_addr, cur_addr_d;
    logic [LEN_W-1:0] remain, remain_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       rvalid_q, rvalid_d;
    logic [1:0]       done_q, done_d;
    logic             rd_read_q, rd_read_d;
    logic [23:0]      rd_addr_q, rd_addr_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             pick;
    logic             own_rready;

`ifdef QSPI_ARB_TIMEOUT_EN
    localparam int              TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;
`endif

    // On a tie the requester that did not own the previous burst wins.
    assign pick       = (bus.req0 && bus.req1) ? ~last_owner : bus.req1;
    assign own_rready = owner ? bus.rready1 : bus.rready0;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d      = state;
        flush_cnt_d  = flush_cnt;
        last_owner_d = last_owner;
        owner_d      = owner;
        cur_addr_d   = cur_addr;
        remain_d     = remain;
        gnt_d        = 2'b00;
        done_d       = 2'b00;
        rd_read_d    = 1'b0;
        rvalid_d     = rvalid_q;
        rd_addr_d    = rd_addr_q;
        rdata_d      = rdata_q;
`ifdef QSPI_ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt;
`endif
        unique case (state)
            S_FLUSH: begin
                if (flush_cnt == FLUSH_LAST) state_d = S_IDLE;
                else                         flush_cnt_d = flush_cnt + 1'b1;
            end
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    gnt_d        = pick ? 2'b10 : 2'b01;
                    owner_d      = pick;
                    last_owner_d = pick;
                    cur_addr_d   = pick ? bus.addr1 : bus.addr0;
                    remain_d     = pick ? bus.len1  : bus.len0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                rd_read_d = 1'b1;
                rd_addr_d = cur_addr;
                state_d   = S_WAIT;
`ifdef QSPI_ARB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (bus.rd_ready) begin
                    rdata_d  = bus.rd_data;
                    rvalid_d = owner ? 2'b10 : 2'b01;
                    state_d  = S_HOLD;
                end
`ifdef QSPI_ARB_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) state_d = S_ISSUE;
                else                          tmo_cnt_d = tmo_cnt + 1'b1;
`endif
            end
            S_HOLD: begin
                if (own_rready) begin
                    rvalid_d = 2'b00;
                    if (remain == '0) begin
                        done_d  = owner ? 2'b10 : 2'b01;
                        state_d = S_IDLE;
                    end else begin
                        remain_d   = remain - 1'b1;
                        cur_addr_d = cur_addr + 24'd1;
                        state_d    = S_ISSUE;
                    end
                end
            end
            default: state_d = S_FLUSH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_FLUSH;
            flush_cnt  <= '0;
            last_owner <= 1'b1;
            owner      <= 1'b0;
            cur_addr   <= '0;
            remain     <= '0;
            gnt_q      <= 2'b00;
            rvalid_q   <= 2'b00;
            done_q     <= 2'b00;
            rd_read_q  <= 1'b0;
            rd_addr_q  <= '0;
            rdata_q    <= '0;
`ifdef QSPI_ARB_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            state      <= state_d;
            flush_cnt  <= flush_cnt_d;
            last_owner <= last_owner_d;
            owner      <= owner_d;
            cur_addr   <= cur_addr_d;
            remain     <= remain_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            done_q     <= done_d;
            rd_read_q  <= rd_read_d;
            rd_addr_q  <= rd_addr_d;
            rdata_q    <= rdata_d;
`ifdef QSPI_ARB_TIMEOUT_EN
            tmo_cnt    <= tmo_cnt_d;
`endif
        end
    end

    assign bus.gnt0    = gnt_q[0];
    assign bus.gnt1    = gnt_q[1];
    assign bus.rvalid0 = rvalid_q[0];
    assign bus.rvalid1 = rvalid_q[1];
    assign bus.done0   = done_q[0];
    assign bus.done1   = done_q[1];
    assign bus.rd_read = rd_read_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.rdata   = rdata_q;
endmodule

// File: tb/tb_qspi_flash_arbiter.sv
// Directed scoreboard bench for qspi_flash_arbiter: tie/round-robin, single byte, backpressure,
// address wrap, reset mid-burst, and (with QSPI_ARB_TIMEOUT_EN) the read retry.
module tb_qspi_flash_arbiter;
    localparam int LEN_W        = 8;
    localparam int FLUSH_CYCLES = 32;
    localparam int TIMEOUT      = 63;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    qspi_flash_arbiter_if #(.LEN_W(LEN_W)) bus ();

    qspi_flash_arbiter #(
        .LEN_W(LEN_W), .FLUSH_CYCLES(FLUSH_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] exp_addr_q[$];
    logic [7:0]  exp_byte_q[$];
    int rd_cnt = 0, rd_cyc = 0, rdy_cyc = 0, drop_cyc = 0, hs_cyc = 0;
    bit drop_next = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flash contents seen through the reader model.
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        return a[23:16] ^ a[15:8] ^ a[7:0] ^ 8'hE5;
    endfunction

    function automatic logic g(input bit w);  return w ? bus.gnt1    : bus.gnt0;    endfunction
    function automatic logic rv(input bit w); return w ? bus.rvalid1 : bus.rvalid0; endfunction
    function automatic logic dn(input bit w); return w ? bus.done1   : bus.done0;   endfunction

    task automatic set_rready(input bit w, input logic v);
        if (w) bus.rready1 = v; else bus.rready0 = v;
    endtask

    task automatic push_burst(input logic [23:0] a, input int len);
        logic [23:0] ai;
        for (int i = 0; i <= len; i++) begin
            ai = a + 24'(i);
            exp_addr_q.push_back(ai);
            exp_byte_q.push_back(flash_byte(ai));
        end
    endtask

    task automatic wait_gnt(input bit who, input logic [23:0] a, input int budget);
        int t;
        t = 0;
        while (g(who) !== 1'b1 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("gnt", g(who), 1);
        check("gnt_other", g(!who), 0);
        if (who) bus.req1 = 1'b0; else bus.req0 = 1'b0;
        @(negedge clk);
        check("gnt_pulse", g(who), 0);
        check("rd_read_after_gnt", bus.rd_read, 1);
        check("rd_addr_issue", bus.rd_addr, a);
    endtask

    task automatic consume(input bit who, input int n, input int hold_at);
        int t, c0;
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (rv(who) !== 1'b1 && t < 200) begin
                @(negedge clk);
                t++;
            end
            check("rvalid", rv(who), 1);
            check("rvalid_latency", cyc, rdy_cyc + 1);
            if (i > 0) check("reissue_latency", rd_cyc, hs_cyc + 2);
            check("other_rvalid", rv(!who), 0);
            e = (exp_byte_q.size() != 0) ? exp_byte_q.pop_front() : 8'hxx;
            check("rdata", bus.rdata, e);
            if (i == hold_at) begin
                c0 = rd_cnt;
                repeat (10) begin
                    @(negedge clk);
                    check("hold_rvalid", rv(who), 1);
                    check("hold_rdata", bus.rdata, e);
                end
                check("hold_no_read", rd_cnt, c0);
            end
            set_rready(who, 1'b1);
            hs_cyc = cyc;
            @(negedge clk);
            set_rready(who, 1'b0);
            check("rvalid_drop", rv(who), 0);
            check("done", dn(who), (i == n - 1) ? 1 : 0);
            check("done_other", dn(!who), 0);
            check("no_gnt_with_done", {bus.gnt0, bus.gnt1}, 0);
        end
        @(negedge clk);
        check("done_pulse", dn(who), 0);
    endtask

    // Flash reader model: checks each read address, answers 3 cycles later unless told to drop.
    initial begin
        logic [23:0] a;
        bus.rd_ready = 1'b0;
        bus.rd_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.rd_read === 1'b1) begin
                a = bus.rd_addr;
                rd_cnt++;
                rd_cyc = cyc;
                if (exp_addr_q.size() == 0) check("rd_unexpected", 1, 0);
                else                        check("rd_addr", a, exp_addr_q.pop_front());
                @(negedge clk);
                check("rd_read_pulse", bus.rd_read, 0);
                if (drop_next) begin
                    drop_next = 1'b0;
                    drop_cyc  = rd_cyc;
                end else begin
                    repeat (2) @(negedge clk);
                    bus.rd_ready = 1'b1;
                    bus.rd_data  = flash_byte(a);
                    rdy_cyc      = cyc;
                    @(negedge clk);
                    bus.rd_ready = 1'b0;
                    bus.rd_data  = 8'h00;
                end
            end
        end
    end

    initial begin
        #300us;
        $display("FAIL watchdog: observed=hang expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start, rel_cyc;
        rst = 1'b1;
        bus.req0 = 1'b0; bus.addr0 = '0; bus.len0 = '0; bus.rready0 = 1'b0;
        bus.req1 = 1'b0; bus.addr1 = '0; bus.len1 = '0; bus.rready1 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1,
                             bus.done0, bus.done1, bus.rd_read}, 0);
        check("reset_rd_addr", bus.rd_addr, 0);
        check("reset_rdata", bus.rdata, 0);

        // Tie from reset: requester 0 first, then 1.
        push_burst(24'h100000, 1);
        push_burst(24'h200000, 0);
        bus.req0 = 1'b1; bus.addr0 = 24'h100000; bus.len0 = 8'd1;
        bus.req1 = 1'b1; bus.addr1 = 24'h200000; bus.len1 = 8'd0;
        rst = 1'b0;
        wait_gnt(1'b0, 24'h100000, 40);
        consume(1'b0, 2, -1);
        wait_gnt(1'b1, 24'h200000, 5);
        consume(1'b1, 1, -1);

        // Tie again: ownership alternates back to requester 0.
        push_burst(24'h300000, 0);
        push_burst(24'h300100, 0);
        bus.req0 = 1'b1; bus.addr0 = 24'h300000; bus.len0 = 8'd0;
        bus.req1 = 1'b1; bus.addr1 = 24'h300100; bus.len1 = 8'd0;
        wait_gnt(1'b0, 24'h300000, 5);
        consume(1'b0, 1, -1);
        wait_gnt(1'b1, 24'h300100, 5);
        consume(1'b1, 1, -1);

        // Single byte with a known flash value.
        exp_addr_q.push_back(24'h400000);
        exp_byte_q.push_back(8'hA5);
        bus.req0 = 1'b1; bus.addr0 = 24'h400000; bus.len0 = 8'd0;
        wait_gnt(1'b0, 24'h400000, 5);
        consume(1'b0, 1, -1);

        // Four-byte burst with 10 cycles of backpressure on the third byte.
        start = rd_cnt;
        push_burst(24'h400010, 3);
        bus.req1 = 1'b1; bus.addr1 = 24'h400010; bus.len1 = 8'd3;
        wait_gnt(1'b1, 24'h400010, 5);
        consume(1'b1, 4, 2);
        check("burst_read_count", rd_cnt - start, 4);

        // Address wrap at the top of the 24-bit space.
        push_burst(24'hFFFFFE, 2);
        bus.req0 = 1'b1; bus.addr0 = 24'hFFFFFE; bus.len0 = 8'd2;
        wait_gnt(1'b0, 24'hFFFFFE, 5);
        consume(1'b0, 3, -1);

`ifdef QSPI_ARB_TIMEOUT_EN
        // First read is dropped by the reader; the arbiter retries the same address.
        exp_addr_q.push_back(24'h600000);
        push_burst(24'h600000, 0);
        drop_next = 1'b1;
        bus.req0 = 1'b1; bus.addr0 = 24'h600000; bus.len0 = 8'd0;
        wait_gnt(1'b0, 24'h600000, 5);
        consume(1'b0, 1, -1);
        check("retry_gap", rd_cyc - drop_cyc, TIMEOUT + 1);
`endif

        // Reset during WAIT of an 8-byte burst; the reader answers during FLUSH.
        push_burst(24'h500000, 7);
        bus.req0 = 1'b1; bus.addr0 = 24'h500000; bus.len0 = 8'd7;
        wait_gnt(1'b0, 24'h500000, 5);
        @(negedge clk);
        rst = 1'b1;
        bus.req0 = 1'b1; bus.len0 = 8'd1;
        #1;
        check("midreset_ctrl", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1,
                                bus.done0, bus.done1, bus.rd_read}, 0);
        check("midreset_rd_addr", bus.rd_addr, 0);
        check("midreset_rdata", bus.rdata, 0);
        exp_addr_q.delete();
        exp_byte_q.delete();
        push_burst(24'h500000, 1);
        @(negedge clk);
        rst = 1'b0;
        rel_cyc = cyc;
        for (int k = 0; k < FLUSH_CYCLES; k++) begin
            @(negedge clk);
            check("flush_quiet", {bus.gnt0, bus.rvalid0, bus.done0, bus.rd_read}, 0);
        end
        check("stale_rdy_in_flush", rdy_cyc > rel_cyc, 1);
        @(negedge clk);
        wait_gnt(1'b0, 24'h500000, 0);
        consume(1'b0, 2, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
